lms_fir_err: RTL

Filter/error stage of the 16-tap LMS adaptive filter. It accepts one input sample x and one desired sample d per handshake, shifts x into the tap delay line, and computes y = Σ w_k·x[n−k] with one multiply-accumulate per cycle. It then forms e = d − y and pulses weight_cal_state. It reads the 32-bit weight registers and drives the e/reff_* inputs and the update strobe of the weight-update block.

---
 rtl/lms_fir_err.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/lms_fir_err.sv
// Filter/error stage of the 16-tap LMS adaptive filter: serial MAC over the tap delay line, then e = d - y.
// Optional build macro LMS_FIR_ROUND_EN rounds the Q-format output half toward +inf instead of flooring.
module lms_fir_err #(
  parameter int TAPS  = 16,
  parameter int DW    = 14,
  parameter int WW    = 32,
  parameter int WFRAC = 25
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [DW-1:0]        x_in,
  input  logic [DW-1:0]        d_in,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [TAPS*WW-1:0]   weights,
  output logic [TAPS*DW-1:0]   reff,
  output logic [DW-1:0]        y_out,
  output logic [DW-1:0]        e_out,
  output logic                 out_valid,
  output logic                 weight_cal_state
);

  localparam int IW = $clog2(TAPS);
  localparam int PW = DW + WW;
  localparam int AW = PW + IW;

  localparam logic signed [AW-1:0] Y_MAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] Y_MIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};
  localparam logic signed [DW-1:0] S_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] S_MIN = {1'b1, {(DW-1){1'b0}}};
  localparam logic [IW-1:0]        LAST_IDX = IW'(TAPS - 1);

  typedef enum logic [1:0] {IDLE, MAC, ERR, UPD} state_t;

  state_t                state_q, state_d;
  logic signed [DW-1:0]  reff_q [TAPS];
  logic signed [DW-1:0]  reff_d [TAPS];
  logic signed [DW-1:0]  d_q, d_d, y_q, y_d, e_q, e_d;
  logic signed [AW-1:0]  acc_q, acc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  pulse_q, pulse_d;

  logic signed [WW-1:0]  w_sel;
  logic signed [DW-1:0]  x_sel;
  logic signed [PW-1:0]  prod;
  logic signed [AW-1:0]  acc_rnd, acc_shift;
  logic signed [DW-1:0]  y_sat, e_sat;
  logic signed [DW:0]    e_wide;

  always_comb begin
    w_sel = $signed(weights[idx_q*WW +: WW]);
    x_sel = reff_q[idx_q];
    prod  = PW'(w_sel) * PW'(x_sel);
`ifdef LMS_FIR_ROUND_EN
    acc_rnd = acc_q + (AW'(1) <<< (WFRAC - 1));
`else
    acc_rnd = acc_q;
`endif
    acc_shift = acc_rnd >>> WFRAC;
    if (acc_shift > Y_MAX) begin
      y_sat = S_MAX;
    end else if (acc_shift < Y_MIN) begin
      y_sat = S_MIN;
    end else begin
      y_sat = acc_shift[DW-1:0];
    end
    // One extra bit is enough for d - y; overflow shows as the top two bits disagreeing.
    e_wide = {d_q[DW-1], d_q} - {y_sat[DW-1], y_sat};
    if (e_wide[DW] != e_wide[DW-1]) begin
      e_sat = e_wide[DW] ? S_MIN : S_MAX;
    end else begin
      e_sat = e_wide[DW-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    reff_d  = reff_q;
    d_d     = d_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    y_d     = y_q;
    e_d     = e_q;
    pulse_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          reff_d[0] = x_in;
          for (int k = 1; k < TAPS; k++) reff_d[k] = reff_q[k-1];
          d_d     = d_in;
          acc_d   = '0;
          idx_d   = '0;
          state_d = MAC;
        end
      end
      MAC: begin
        acc_d = acc_q + AW'(prod);
        idx_d = idx_q + IW'(1);
        if (idx_q == LAST_IDX) state_d = ERR;
      end
      ERR: begin
        y_d     = y_sat;
        e_d     = e_sat;
        state_d = UPD;
      end
      UPD: begin
        pulse_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      reff_q  <= '{default: '0};
      d_q     <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      y_q     <= '0;
      e_q     <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      reff_q  <= reff_d;
      d_q     <= d_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      y_q     <= y_d;
      e_q     <= e_d;
      pulse_q <= pulse_d;
    end
  end

  // The strobe cycle is not an accepting cycle, so a held in_valid waits one more edge.
  assign in_ready         = (state_q == IDLE) && !pulse_q;
  assign out_valid        = pulse_q;
  assign weight_cal_state = pulse_q;
  assign y_out            = y_q;
  assign e_out            = e_q;

  for (genvar g = 0; g < TAPS; g++) begin : g_reff
    assign reff[g*DW +: DW] = reff_q[g];
  end

endmodule
